axi_lite_responder: RTL and testbench
=====================================

Name: axi_lite_responder

Overview:
- AXI4-Lite slave front-end for the prewrapper datapath.
- Terminates the host's AW/W/B/AR/R channels and converts them into the datapath's simple register-access port: word write address/data with an enable pulse, and word read address with returned data.
- Sits between the SoC interconnect and the prewrapper datapath.
- It is the responder end of the register-access interface whose register-file end lives in the datapath.

Parameters:
- ADDR_W, 32: AXI byte-address width.
- RD_LATENCY, 0: cycles from axi_rd_en to valid axi_rd_msg. Legal range 0..3; 0 means combinational.
- MAX_WORD_ADDR, 32'h0000021F: highest decoded word address. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- s_axi_awaddr  in  ADDR_W  write byte address
- s_axi_awvalid  in  1  write-address valid
- s_axi_awready  out  1  write-address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write byte strobes
- s_axi_wvalid  in  1  write-data valid
- s_axi_wready  out  1  write-data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write-response valid
- s_axi_bready  in  1  write-response ready
- s_axi_araddr  in  ADDR_W  read byte address
- s_axi_arvalid  in  1  read-address valid
- s_axi_arready  out  1  read-address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read valid
- s_axi_rready  in  1  read ready
- axi_wr_addr  out  32  word address (byte address >> 2, zero-extended)
- axi_wr_msg  out  32  write data to datapath
- axi_wr_en  out  1  one-cycle write pulse
- axi_rd_addr  out  32  word address to datapath
- axi_rd_en  out  1  read request, high for 1+RD_LATENCY cycles
- axi_rd_msg  in  32  read data from datapath

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, including readys and valids.
  - FSMs return to IDLE; any in-flight transaction is discarded with no response.
  - First ready rises in the first cycle after reset deasserts.
- Write FSM states: W_IDLE, W_ISSUE, W_RESP.
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in either order or in the same cycle; each is held in a capture register with a "have" flag.
  - W_IDLE -> W_ISSUE when both flags are set.
  - W_ISSUE (one cycle):
    - If wstrb==4'hF: axi_wr_en=1 and bresp=OKAY (2'b00).
    - Otherwise: no write and bresp=SLVERR (2'b10).
  - W_RESP: bvalid=1, held with bresp stable until bready. Then flags clear and the FSM returns to W_IDLE.
  - Latency: both handshakes complete in cycle N -> axi_wr_en in N+1 -> bvalid in N+2.
  - One outstanding write; awready and wready stay low from capture until the B handshake.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. AR handshake captures the address.
  - R_WAIT: axi_rd_en=1 and axi_rd_addr held stable for 1+RD_LATENCY cycles. A down-counter loads RD_LATENCY. axi_rd_msg is sampled into rdata in the last R_WAIT cycle.
  - R_RESP: rvalid=1, holding rdata and rresp=OKAY until rready, then return to R_IDLE.
  - Latency: AR in cycle N -> rvalid in N+2+RD_LATENCY.
- Channels are independent, except for the ordering rule below.
- Same-address ordering:
  - A write issue and a read launch in the same cycle: the write goes first and the read's R_WAIT is delayed by one cycle, so the read returns post-write data.
  - A read already in R_WAIT is never stalled.
- Address arithmetic: word address = addr[ADDR_W-1:2]. Byte-offset bits [1:0] are ignored.
- axi_wr_addr and axi_wr_msg hold their last value when axi_wr_en=0.
- axi_rd_addr holds its last value when axi_rd_en=0.
- Protocol rules:
  - No combinational path from any valid to any ready.
  - A response valid never depends on the response ready.

Optional Feature:
- Macro AXI_LITE_DECERR_EN.
- When defined: a word address greater than MAX_WORD_ADDR gets response DECERR (2'b11).
  - Writes: no axi_wr_en pulse.
  - Reads: no axi_rd_en; rdata=32'h0; latency unchanged.
  - For a write with both a bad strobe and a bad address, DECERR takes precedence.
- When undefined: all addresses are passed through and answered OKAY, subject only to the strobe check.

Decomposition:
- Shared package/include holds:
  - Response codes RESP_OKAY/RESP_SLVERR/RESP_DECERR.
  - Write-state and read-state encodings.
  - Full-strobe constant 4'hF.
- One natural sub-module, axi_lite_rd_channel: the read FSM with its latency counter, instantiated by the top. The write FSM stays in the top.

Test Plan:
- AW(0x4) and W(0xDEADBEEF, strb F) in the same cycle N -> axi_wr_en at N+1 with addr 1 and msg 0xDEADBEEF; bvalid at N+2 with OKAY.
- W(0x12345678) sent 3 cycles before AW(0x40) -> a single write pulse to word 0x10 with data 0x12345678; awready/wready low until B completes.
- Write with wstrb=4'h3 -> no axi_wr_en; bresp=SLVERR.
- RD_LATENCY=2, AR(0x8), datapath returns 0xCAFEF00D -> axi_rd_en high 3 cycles with addr 2; rvalid at N+4 with data 0xCAFEF00D; rready held low 5 cycles -> rdata stable.
- Write issue and read launch both at word 0x10 in the same cycle -> read delayed one cycle and returns the written value.
- reset=0 while bvalid=1 -> bvalid=0 immediately; after release a new write completes normally. With AXI_LITE_DECERR_EN, AR(0x1000) -> rresp=DECERR, rdata=0, no axi_rd_en.

Source files
------------

// File: rtl/axi_lite_responder_pkg.sv
// axi_lite_responder_pkg: response codes, FSM state encodings and strobe
// constant shared by the AXI4-Lite responder and its read channel.
package axi_lite_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] STRB_FULL = 4'hF;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_ISSUE = 2'd1,
        W_RESP  = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    // A decode error outranks a partial-strobe error.
    function automatic logic [1:0] wr_resp(input logic strb_full, input logic addr_ok);
        if (!addr_ok) begin
            return RESP_DECERR;
        end
        if (!strb_full) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_responder_if.sv
// axi_lite_responder_if: AXI4-Lite AW/W/B/AR/R bundle. "slave" is the
// responder's view, "master" the host's view.
interface axi_lite_responder_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_rd_channel.sv
// axi_lite_rd_channel: AR/R side of the responder. Captures the read address,
// drives the datapath read port for 1+RD_LATENCY cycles, then presents R.
// Decode errors are only produced when AXI_LITE_DECERR_EN is defined.
module axi_lite_rd_channel
    import axi_lite_responder_pkg::*;
#(
    parameter int          ADDR_W        = 32,
    parameter int          RD_LATENCY    = 0,
    parameter logic [31:0] MAX_WORD_ADDR = 32'h0000_021F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready_en,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic              hold_launch,
    output logic [31:0]       rd_addr,
    output logic              rd_en,
    input  logic [31:0]       rd_msg
);
    r_state_t          state_reg, state_next;
    logic              have_ar_reg;
    logic [ADDR_W-3:0] ar_word_reg;
    logic [1:0]        cnt_reg;
    logic [31:0]       rd_addr_reg;
    logic              rd_ok_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        rresp_reg;
    logic              ar_hs;
    logic              launch;
    logic [31:0]       cur_word32;
    logic              cur_addr_ok;
    logic              unused_bits;

    assign arready    = ready_en && (state_reg == R_IDLE) && !have_ar_reg;
    assign ar_hs      = arvalid && arready;
    assign cur_word32 = ar_hs ? 32'(araddr[ADDR_W-1:2]) : 32'(ar_word_reg);

`ifdef AXI_LITE_DECERR_EN
    assign cur_addr_ok = (cur_word32 <= MAX_WORD_ADDR);
    assign unused_bits = ^araddr[1:0];
`else
    // The range limit only matters when decode errors are enabled.
    assign cur_addr_ok = 1'b1;
    assign unused_bits = ^{araddr[1:0], cur_word32 > MAX_WORD_ADDR};
`endif

    assign rd_en   = (state_reg == R_WAIT) && rd_ok_reg;
    assign rd_addr = rd_addr_reg;
    assign rvalid  = (state_reg == R_RESP);
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;

    // Read FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= R_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: a launch waits one cycle when a write issues alongside it.
    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        case (state_reg)
            R_IDLE: begin
                if ((have_ar_reg || ar_hs) && !hold_launch) begin
                    launch     = 1'b1;
                    state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (cnt_reg == 2'd0) begin
                    state_next = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) begin
                    state_next = R_IDLE;
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    // Address capture, latency countdown and read-data sampling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have_ar_reg <= 1'b0;
            ar_word_reg <= '0;
            cnt_reg     <= 2'd0;
            rd_addr_reg <= 32'h0;
            rd_ok_reg   <= 1'b0;
            rdata_reg   <= 32'h0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                ar_word_reg <= araddr[ADDR_W-1:2];
                have_ar_reg <= 1'b1;
            end
            if (launch) begin
                have_ar_reg <= 1'b0;
                cnt_reg     <= 2'(RD_LATENCY);
                rd_ok_reg   <= cur_addr_ok;
                rresp_reg   <= cur_addr_ok ? RESP_OKAY : RESP_DECERR;
                if (cur_addr_ok) begin
                    rd_addr_reg <= cur_word32;
                end
            end else if ((state_reg == R_WAIT) && (cnt_reg != 2'd0)) begin
                cnt_reg <= cnt_reg - 2'd1;
            end
            if ((state_reg == R_WAIT) && (cnt_reg == 2'd0)) begin
                rdata_reg <= rd_ok_reg ? rd_msg : 32'h0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_responder.sv
// axi_lite_responder: AXI4-Lite slave front-end turning AW/W/B and AR/R into a
// word-addressed register port. The write FSM lives here; the read FSM is in
// axi_lite_rd_channel. Optional AXI_LITE_DECERR_EN answers addresses above
// MAX_WORD_ADDR with DECERR instead of touching the datapath.
module axi_lite_responder
    import axi_lite_responder_pkg::*;
#(
    parameter int          ADDR_W        = 32,
    parameter int          RD_LATENCY    = 0,
    parameter logic [31:0] MAX_WORD_ADDR = 32'h0000_021F
) (
    input  logic                clk,
    input  logic                reset,
    axi_lite_responder_if.slave s_axi,
    output logic [31:0]         axi_wr_addr,
    output logic [31:0]         axi_wr_msg,
    output logic                axi_wr_en,
    output logic [31:0]         axi_rd_addr,
    output logic                axi_rd_en,
    input  logic [31:0]         axi_rd_msg
);
    w_state_t          w_state_reg, w_state_next;
    logic              active_reg;
    logic              have_aw_reg, have_w_reg;
    logic [ADDR_W-3:0] aw_word_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic [31:0]       wr_addr_reg, wr_msg_reg;
    logic              wr_en_reg;
    logic [1:0]        bresp_reg;
    logic              awready_int, wready_int;
    logic              aw_hs, w_hs, issue_go;
    logic [31:0]       cur_word32, cur_data;
    logic              cur_strb_full, cur_addr_ok;
    logic              unused_addr_bits;

    // Readies depend only on registered state; active_reg keeps them low in reset.
    assign awready_int = active_reg && (w_state_reg == W_IDLE) && !have_aw_reg;
    assign wready_int  = active_reg && (w_state_reg == W_IDLE) && !have_w_reg;
    assign aw_hs       = s_axi.awvalid && awready_int;
    assign w_hs        = s_axi.wvalid && wready_int;

    // Same-cycle handshakes feed the issue directly to save a cycle.
    assign cur_word32    = aw_hs ? 32'(s_axi.awaddr[ADDR_W-1:2]) : 32'(aw_word_reg);
    assign cur_data      = w_hs ? s_axi.wdata : wdata_reg;
    assign cur_strb_full = (w_hs ? s_axi.wstrb : wstrb_reg) == STRB_FULL;
    assign unused_addr_bits = ^s_axi.awaddr[1:0];

`ifdef AXI_LITE_DECERR_EN
    assign cur_addr_ok = (cur_word32 <= MAX_WORD_ADDR);
`else
    assign cur_addr_ok = 1'b1;
`endif

    assign s_axi.awready = awready_int;
    assign s_axi.wready  = wready_int;
    assign s_axi.bvalid  = (w_state_reg == W_RESP);
    assign s_axi.bresp   = bresp_reg;
    assign axi_wr_addr   = wr_addr_reg;
    assign axi_wr_msg    = wr_msg_reg;
    assign axi_wr_en     = wr_en_reg;

    // Write FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_reg <= W_IDLE;
        end else begin
            w_state_reg <= w_state_next;
        end
    end

    // Next state: issue once both AW and W are held (or arriving now).
    always_comb begin
        w_state_next = w_state_reg;
        issue_go     = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if ((have_aw_reg || aw_hs) && (have_w_reg || w_hs)) begin
                    issue_go     = 1'b1;
                    w_state_next = W_ISSUE;
                end
            end
            W_ISSUE: w_state_next = W_RESP;
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // AW/W capture, registered write port and response code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_reg  <= 1'b0;
            have_aw_reg <= 1'b0;
            have_w_reg  <= 1'b0;
            aw_word_reg <= '0;
            wdata_reg   <= 32'h0;
            wstrb_reg   <= 4'h0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= 32'h0;
            wr_msg_reg  <= 32'h0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            active_reg <= 1'b1;
            wr_en_reg  <= 1'b0;
            if (aw_hs) begin
                have_aw_reg <= 1'b1;
                aw_word_reg <= s_axi.awaddr[ADDR_W-1:2];
            end
            if (w_hs) begin
                have_w_reg <= 1'b1;
                wdata_reg  <= s_axi.wdata;
                wstrb_reg  <= s_axi.wstrb;
            end
            if (issue_go) begin
                bresp_reg <= wr_resp(cur_strb_full, cur_addr_ok);
                if (cur_strb_full && cur_addr_ok) begin
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= cur_word32;
                    wr_msg_reg  <= cur_data;
                end
            end
            if ((w_state_reg == W_RESP) && s_axi.bready) begin
                have_aw_reg <= 1'b0;
                have_w_reg  <= 1'b0;
            end
        end
    end

    axi_lite_rd_channel #(
        .ADDR_W        (ADDR_W),
        .RD_LATENCY    (RD_LATENCY),
        .MAX_WORD_ADDR (MAX_WORD_ADDR)
    ) u_rd_channel (
        .clk         (clk),
        .reset       (reset),
        .ready_en    (active_reg),
        .araddr      (s_axi.araddr),
        .arvalid     (s_axi.arvalid),
        .arready     (s_axi.arready),
        .rdata       (s_axi.rdata),
        .rresp       (s_axi.rresp),
        .rvalid      (s_axi.rvalid),
        .rready      (s_axi.rready),
        .hold_launch (issue_go),
        .rd_addr     (axi_rd_addr),
        .rd_en       (axi_rd_en),
        .rd_msg      (axi_rd_msg)
    );

endmodule

// File: tb/tb_axi_lite_responder.sv
// tb_axi_lite_responder: directed bench for axi_lite_responder with
// RD_LATENCY=2 and a small register-file model on the datapath port.
// Build with AXI_LITE_DECERR_EN to also cover the decode-error path.
module tb_axi_lite_responder;
    import axi_lite_responder_pkg::*;

    localparam int RD_LAT = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] axi_wr_addr, axi_wr_msg, axi_rd_addr, axi_rd_msg;
    logic        axi_wr_en, axi_rd_en;
    logic [31:0] mem [0:63];
    int          wr_pulses = 0;
    int          rd_cycles = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    axi_lite_responder_if #(.ADDR_W(32)) s_axi ();

    axi_lite_responder #(
        .ADDR_W        (32),
        .RD_LATENCY    (RD_LAT),
        .MAX_WORD_ADDR (32'h0000_021F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_axi       (s_axi),
        .axi_wr_addr (axi_wr_addr),
        .axi_wr_msg  (axi_wr_msg),
        .axi_wr_en   (axi_wr_en),
        .axi_rd_addr (axi_rd_addr),
        .axi_rd_en   (axi_rd_en),
        .axi_rd_msg  (axi_rd_msg)
    );

    always #5 clk = ~clk;

    // Datapath model: register file plus counters of write pulses and read cycles.
    always @(posedge clk) begin
        if (axi_wr_en) begin
            mem[axi_wr_addr[5:0]] <= axi_wr_msg;
            wr_pulses <= wr_pulses + 1;
        end
        if (axi_rd_en) begin
            rd_cycles <= rd_cycles + 1;
        end
    end

    assign axi_rd_msg = mem[axi_rd_addr[5:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_pend, w_pend, aw_hit, w_hit, got;
        s_axi.awaddr  = addr;
        s_axi.wdata   = data;
        s_axi.wstrb   = strb;
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = 1'b1;
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        for (int i = 0; i < 20 && (aw_pend || w_pend); i++) begin
            aw_hit = s_axi.awready;
            w_hit  = s_axi.wready;
            @(negedge clk);
            if (aw_hit) begin aw_pend = 1'b0; s_axi.awvalid = 1'b0; end
            if (w_hit)  begin w_pend  = 1'b0; s_axi.wvalid  = 1'b0; end
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        got  = 1'b0;
        resp = 2'b01;
        for (int i = 0; i < 20 && !got; i++) begin
            if (s_axi.bvalid) begin
                got  = 1'b1;
                resp = s_axi.bresp;
            end else begin
                @(negedge clk);
            end
        end
        check("wr_bvalid_seen", {31'b0, got}, 32'd1);
        s_axi.bready = 1'b1;
        @(negedge clk);
        s_axi.bready = 1'b0;
        $display("write addr=%08h data=%08h strb=%h resp=%0d", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit ar_pend, hit, got;
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        ar_pend = 1'b1;
        for (int i = 0; i < 20 && ar_pend; i++) begin
            hit = s_axi.arready;
            @(negedge clk);
            if (hit) begin ar_pend = 1'b0; s_axi.arvalid = 1'b0; end
        end
        s_axi.arvalid = 1'b0;
        got  = 1'b0;
        data = 32'h0;
        resp = 2'b01;
        for (int i = 0; i < 20 && !got; i++) begin
            if (s_axi.rvalid) begin
                got  = 1'b1;
                data = s_axi.rdata;
                resp = s_axi.rresp;
            end else begin
                @(negedge clk);
            end
        end
        check("rd_rvalid_seen", {31'b0, got}, 32'd1);
        s_axi.rready = 1'b1;
        @(negedge clk);
        s_axi.rready = 1'b0;
        $display("read  addr=%08h data=%08h resp=%0d", addr, data, resp);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int          base_wr, base_rd, k;
        bit          got;

        s_axi.awaddr = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0;  s_axi.wstrb = '0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_awready", s_axi.awready, 0);
        check("rst_wready",  s_axi.wready, 0);
        check("rst_arready", s_axi.arready, 0);
        check("rst_bvalid",  s_axi.bvalid, 0);
        check("rst_rvalid",  s_axi.rvalid, 0);
        check("rst_wr_en",   axi_wr_en, 0);
        check("rst_rd_en",   axi_rd_en, 0);
        reset = 1'b1;
        @(negedge clk);
        check("up_awready", s_axi.awready, 1);
        check("up_wready",  s_axi.wready, 1);
        check("up_arready", s_axi.arready, 1);

        // AW and W together: wr_en at N+1, bvalid at N+2.
        base_wr = wr_pulses;
        s_axi.awaddr = 32'h4; s_axi.wdata = 32'hDEAD_BEEF; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        @(negedge clk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        check("t1_wr_en",    axi_wr_en, 1);
        check("t1_wr_addr",  axi_wr_addr, 32'h1);
        check("t1_wr_msg",   axi_wr_msg, 32'hDEAD_BEEF);
        check("t1_bv_early", s_axi.bvalid, 0);
        check("t1_awready",  s_axi.awready, 0);
        @(negedge clk);
        check("t1_bvalid",   s_axi.bvalid, 1);
        check("t1_bresp",    s_axi.bresp, RESP_OKAY);
        check("t1_wr_en_off", axi_wr_en, 0);
        s_axi.bready = 1'b1;
        @(negedge clk);
        s_axi.bready = 1'b0;
        check("t1_bdone",    s_axi.bvalid, 0);
        check("t1_pulses",   wr_pulses - base_wr, 1);
        $display("write addr=00000004 data=deadbeef strb=f same-cycle");

        // W three cycles ahead of AW.
        base_wr = wr_pulses;
        s_axi.wdata = 32'h1234_5678; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        @(negedge clk);
        s_axi.wvalid = 1'b0;
        check("t2_wready_low", s_axi.wready, 0);
        check("t2_awready",    s_axi.awready, 1);
        @(negedge clk);
        check("t2_no_wr_yet",  axi_wr_en, 0);
        @(negedge clk);
        s_axi.awaddr = 32'h40; s_axi.awvalid = 1'b1;
        @(negedge clk);
        s_axi.awvalid = 1'b0;
        check("t2_wr_en",      axi_wr_en, 1);
        check("t2_wr_addr",    axi_wr_addr, 32'h10);
        check("t2_wr_msg",     axi_wr_msg, 32'h1234_5678);
        check("t2_aw_low",     s_axi.awready, 0);
        check("t2_w_low",      s_axi.wready, 0);
        @(negedge clk);
        check("t2_bvalid",     s_axi.bvalid, 1);
        check("t2_aw_low_b",   s_axi.awready, 0);
        s_axi.bready = 1'b1;
        @(negedge clk);
        s_axi.bready = 1'b0;
        check("t2_aw_back",    s_axi.awready, 1);
        check("t2_pulses",     wr_pulses - base_wr, 1);
        $display("write addr=00000040 data=12345678 strb=f w-first");

        // Partial strobe: SLVERR and no write; then a full write to word 2.
        base_wr = wr_pulses;
        axi_write(32'h8, 32'h1111_1111, 4'h3, resp);
        check("t3_slverr",  resp, RESP_SLVERR);
        check("t3_no_wr",   wr_pulses - base_wr, 0);
        axi_write(32'h8, 32'hCAFE_F00D, 4'hF, resp);
        check("t3_okay",    resp, RESP_OKAY);

        // Read of word 2 with RD_LATENCY=2 and a stalled R channel.
        base_rd = rd_cycles;
        s_axi.araddr = 32'h8; s_axi.arvalid = 1'b1;
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        check("t4_rd_en",    axi_rd_en, 1);
        check("t4_rd_addr",  axi_rd_addr, 32'h2);
        @(negedge clk);
        @(negedge clk);
        check("t4_rd_en3",   axi_rd_en, 1);
        check("t4_rv_early", s_axi.rvalid, 0);
        @(negedge clk);
        check("t4_rvalid",   s_axi.rvalid, 1);
        check("t4_rdata",    s_axi.rdata, 32'hCAFE_F00D);
        check("t4_rresp",    s_axi.rresp, RESP_OKAY);
        check("t4_rd_off",   axi_rd_en, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_rv", s_axi.rvalid, 1);
            check("t4_hold_rd", s_axi.rdata, 32'hCAFE_F00D);
        end
        s_axi.rready = 1'b1;
        @(negedge clk);
        s_axi.rready = 1'b0;
        check("t4_rdone",    s_axi.rvalid, 0);
        check("t4_rd_cyc",   rd_cycles - base_rd, 3);
        $display("read  addr=00000008 data=cafef00d latency=%0d", RD_LAT);

        // Write issue and read launch on word 0x10 in the same cycle.
        s_axi.awaddr = 32'h40; s_axi.wdata = 32'hA5A5_A5A5; s_axi.wstrb = 4'hF;
        s_axi.araddr = 32'h40;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.arvalid = 1'b1;
        @(negedge clk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
        check("t5_wr_en",    axi_wr_en, 1);
        check("t5_rd_held",  axi_rd_en, 0);
        @(negedge clk);
        check("t5_rd_en",    axi_rd_en, 1);
        check("t5_rd_addr",  axi_rd_addr, 32'h10);
        check("t5_bvalid",   s_axi.bvalid, 1);
        s_axi.bready = 1'b1;
        s_axi.rready = 1'b1;
        k = 0;
        got = 1'b0;
        data = 32'h0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            s_axi.bready = 1'b0;
            k++;
            if (s_axi.rvalid) begin
                got  = 1'b1;
                data = s_axi.rdata;
            end
        end
        @(negedge clk);
        s_axi.rready = 1'b0;
        check("t5_rv_cycle", k, 3);
        check("t5_rdata",    data, 32'hA5A5_A5A5);
        $display("write+read addr=00000040 data=%08h", data);

        // Reset while bvalid is high, then a normal write.
        s_axi.awaddr = 32'h4; s_axi.wdata = 32'h5555_0000; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        @(negedge clk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        @(negedge clk);
        check("t6_bvalid",   s_axi.bvalid, 1);
        reset = 1'b0;
        #1;
        check("t6_bv_rst",   s_axi.bvalid, 0);
        check("t6_aw_rst",   s_axi.awready, 0);
        check("t6_wr_rst",   axi_wr_en, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_no_stale", s_axi.bvalid, 0);
        base_wr = wr_pulses;
        axi_write(32'h4, 32'h0000_0077, 4'hF, resp);
        check("t6_resp",     resp, RESP_OKAY);
        check("t6_pulses",   wr_pulses - base_wr, 1);
        axi_read(32'h4, data, resp);
        check("t6_rdback",   data, 32'h0000_0077);

`ifdef AXI_LITE_DECERR_EN
        // Out-of-range accesses get DECERR and never reach the datapath.
        base_rd = rd_cycles;
        axi_read(32'h1000, data, resp);
        check("dec_rresp",   resp, RESP_DECERR);
        check("dec_rdata",   data, 32'h0);
        check("dec_no_rd",   rd_cycles - base_rd, 0);
        base_wr = wr_pulses;
        axi_write(32'h1000, 32'hFFFF_FFFF, 4'h3, resp);
        check("dec_bresp",   resp, RESP_DECERR);
        check("dec_no_wr",   wr_pulses - base_wr, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
